// File: rtl/cal_pkg.sv
// Shared calendar-chain definitions.
//   - Field limits for the day-of-week, date, month, hour and minute counters.
//   - Field-select enum stepped through by the set-mode FSM, which picks the
//     counter whose load strobe is active.
package cal_pkg;

    localparam int DOW_MIN   = 1;
    localparam int DOW_MAX   = 7;
    localparam int DATE_MIN  = 1;
    localparam int MONTH_MIN = 1;
    localparam int MONTH_MAX = 12;
    localparam int HR_MAX    = 23;
    localparam int MIN_MAX   = 59;

    typedef enum logic [2:0] {
        FLD_NONE  = 3'd0,
        FLD_DOW   = 3'd1,
        FLD_DATE  = 3'd2,
        FLD_MONTH = 3'd3,
        FLD_HOUR  = 3'd4,
        FLD_MIN   = 3'd5
    } cal_field_e;

endpackage

// File: rtl/cal_mod_counter_if.sv
// Bus bundle for one calendar modulo counter.
//   master : stage driver (tick/dir_up/load/data/max_in/out_en out; results in)
//   slave  : the counter itself (count/databus/carry/borrow/load_err out)
interface cal_mod_counter_if #(
    parameter int WIDTH = 3
);
    logic             tick;
    logic             dir_up;
    logic             load;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] max_in;
    logic             out_en;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] databus;
    logic             carry;
    logic             borrow;
    logic             load_err;

    modport master (
        output tick, dir_up, load, data, max_in, out_en,
        input  count, databus, carry, borrow, load_err
    );

    modport slave (
        input  tick, dir_up, load, data, max_in, out_en,
        output count, databus, carry, borrow, load_err
    );
endinterface

// File: rtl/cal_range_chk.sv
// Unsigned range classifier: where does value sit relative to [lo, hi]?
//   value, lo, hi : WIDTH-bit operands
//   below/above   : value < lo / value > hi
//   at_lo/at_hi   : value == lo / value == hi
module cal_range_chk #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic             below,
    output logic             above,
    output logic             at_lo,
    output logic             at_hi
);
    assign below = value < lo;
    assign above = value > hi;
    assign at_lo = value == lo;
    assign at_hi = value == hi;
endmodule

// File: rtl/cal_mod_counter.sv
// Up/down modulo counter for one calendar field, range [MIN_VAL, limit].
//   clk   : rising-edge clock
//   clear : asynchronous active-high reset (count <= RESET_VAL)
//   bus   : slave side of cal_mod_counter_if
//     inputs  tick, dir_up, load, data, max_in (DYN_MAX=1 only), out_en
//     outputs count (registered), databus/carry/borrow (combinational),
//             load_err (registered one-cycle pulse on a rejected load)
// Edge priority: load > clamp > tick > hold. carry/borrow are produced in
// the tick cycle so the next stage can use them directly as its tick.
module cal_mod_counter
    import cal_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int MIN_VAL   = DOW_MIN,
    parameter int MAX_VAL   = DOW_MAX,
    parameter int RESET_VAL = 1,
    parameter bit DYN_MAX   = 1'b0
) (
    input  logic             clk,
    input  logic             clear,
    cal_mod_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count_q;
    logic             load_err_q;
    logic             d_below, d_above, d_at_lo, d_at_hi;
    logic             c_below, c_above, c_at_lo, c_at_hi;
    logic             data_ok, clamp_needed, lim_bad;
    logic             unused_ok;

    assign limit = DYN_MAX ? bus.max_in : MAX_V;

    cal_range_chk #(.WIDTH(WIDTH)) u_chk_data (
        .value (bus.data),
        .lo    (MIN_V),
        .hi    (limit),
        .below (d_below),
        .above (d_above),
        .at_lo (d_at_lo),
        .at_hi (d_at_hi)
    );

    cal_range_chk #(.WIDTH(WIDTH)) u_chk_count (
        .value (count_q),
        .lo    (MIN_V),
        .hi    (limit),
        .below (c_below),
        .above (c_above),
        .at_lo (c_at_lo),
        .at_hi (c_at_hi)
    );

    assign data_ok      = ~d_below & ~d_above;
    // Out of range only happens after max_in drops (e.g. 31 -> 30 days).
    assign clamp_needed = c_below | c_above;
    // A limit below MIN_VAL is a bad configuration; pin the count at MIN_VAL
    // so clamping cannot bounce between the two bounds.
    assign lim_bad      = limit < MIN_V;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count_q    <= RESET_V;
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= bus.load & ~data_ok;
            if (bus.load) begin
                if (data_ok)
                    count_q <= bus.data;
            end else if (clamp_needed) begin
                count_q <= (c_below | lim_bad) ? MIN_V : limit;
            end else if (bus.tick) begin
                // Wrap is decided by compare, so no WIDTH overflow is relied on.
                if (bus.dir_up)
                    count_q <= c_at_hi ? MIN_V : count_q + WIDTH'(1);
                else
                    count_q <= c_at_lo ? limit : count_q - WIDTH'(1);
            end
        end
    end

    assign bus.count    = count_q;
    assign bus.databus  = count_q & {WIDTH{bus.out_en}};
    assign bus.load_err = load_err_q;
    assign bus.carry    = ~clear & bus.tick &  bus.dir_up & ~bus.load & c_at_hi & ~clamp_needed;
    assign bus.borrow   = ~clear & bus.tick & ~bus.dir_up & ~bus.load & c_at_lo & ~clamp_needed;

    // Equality flags on the load value are not needed.
    assign unused_ok = &{1'b0, d_at_lo, d_at_hi, bus.max_in};
endmodule
